serial_magnitude_comparator: RTL and testbench

//  Digit-serial magnitude comparator FSM: compares two WORD_W-bit operands streamed DIGIT_W bits/cycle.

---
 rtl/serial_magnitude_comparator_pkg.sv | 22 ++
 rtl/serial_magnitude_comparator_if.sv | 31 +++
 rtl/serial_cmp_digit.sv | 31 +++
 rtl/serial_magnitude_comparator.sv | 116 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM state encoding,
// per-digit/overall compare result encoding and the digit-count helper.
package serial_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_e;

    // Number of digits per operand; word_w must be a multiple of digit_w.
    function automatic int calc_ndig(input int word_w, input int digit_w);
        return word_w / digit_w;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Control/data bundle between the sequencing logic and the comparator.
//
// Handshake: valid-only, no back-pressure. The comparator consumes a/b on
// every posedge where valid=1, state is RUN and start=0; the master must hold
// valid low when it has no digit. start is a single-cycle command that wins
// over valid in the same cycle. L/E/G, busy and done are registered.
interface serial_magnitude_comparator_if #(
    parameter int DIGIT_W = 1
);
    logic               start;
    logic               msb_first;
    logic               signed_cmp;
    logic               valid;
    logic [DIGIT_W-1:0] a;
    logic [DIGIT_W-1:0] b;
    logic               L;
    logic               E;
    logic               G;
    logic               busy;
    logic               done;

    modport master (
        output start, msb_first, signed_cmp, valid, a, b,
        input  L, E, G, busy, done
    );

    modport slave (
        input  start, msb_first, signed_cmp, valid, a, b,
        output L, E, G, busy, done
    );
endinterface

// File: rtl/serial_cmp_digit.sv
// Combinational DIGIT_W-bit unsigned compare of one digit pair. When
// sign_flip is set the top bit of both digits is inverted first, which turns
// the unsigned compare of the sign digit into a two's-complement compare.
module serial_cmp_digit
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sign_flip,
    output cmp_e               res
);
    logic [DIGIT_W-1:0] fa;
    logic [DIGIT_W-1:0] fb;

    // Optional sign-bit inversion followed by a plain magnitude compare.
    always_comb begin
        fa = a;
        fb = b;
        fa[DIGIT_W-1] = a[DIGIT_W-1] ^ sign_flip;
        fb[DIGIT_W-1] = b[DIGIT_W-1] ^ sign_flip;
        if (fa < fb) begin
            res = CMP_LT;
        end else if (fa > fb) begin
            res = CMP_GT;
        end else begin
            res = CMP_EQ;
        end
    end
endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator. Operands stream in DIGIT_W bits per
// accepted cycle, LSB-first or MSB-first, unsigned or two's complement; the
// order and signedness are captured at start. Result is one-hot L/E/G.
//
// Optional feature macro: SERIAL_CMP_EARLY_DONE_EN -- in MSB-first mode the
// first non-equal digit finishes the comparison immediately; later digits are
// ignored. Without it every comparison consumes exactly NDIG digits.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int DIGIT_W = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus,
    output state_e                        dbg_state
);
    localparam int NDIG = calc_ndig(WORD_W, DIGIT_W);
    localparam int CW   = $clog2(NDIG);
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          msb_q, msb_d;
    logic          sgn_q, sgn_d;
    logic          lock_q, lock_d;
    cmp_e          res_q, res_d;

    logic          accept;
    logic          last_digit;
    logic          sign_digit;
    cmp_e          dig_res;

    // Which digit of the stream carries the sign depends on the arrival order.
    always_comb begin
        last_digit = (count_q == LAST_IDX);
        sign_digit = msb_q ? (count_q == '0) : last_digit;
        accept     = (state_q == ST_RUN) && bus.valid && !bus.start;
    end

    serial_cmp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a         (bus.a),
        .b         (bus.b),
        .sign_flip (sgn_q & sign_digit),
        .res       (dig_res)
    );

    // Register update with synchronous reset back to IDLE / equal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            msb_q   <= 1'b0;
            sgn_q   <= 1'b0;
            lock_q  <= 1'b0;
            res_q   <= CMP_EQ;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            msb_q   <= msb_d;
            sgn_q   <= sgn_d;
            lock_q  <= lock_d;
            res_q   <= res_d;
        end
    end

    // Next-state: start re-arms from any state; RUN folds in accepted digits.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        msb_d   = msb_q;
        sgn_d   = sgn_q;
        lock_d  = lock_q;
        res_d   = res_q;

        if (bus.start) begin
            state_d = ST_RUN;
            count_d = '0;
            msb_d   = bus.msb_first;
            sgn_d   = bus.signed_cmp;
            lock_d  = 1'b0;
            res_d   = CMP_EQ;
        end else if (accept) begin
            count_d = count_q + CW'(1);
            if (msb_q) begin
                // Most significant digits arrive first: the first difference decides.
                if (!lock_q && (dig_res != CMP_EQ)) begin
                    res_d  = dig_res;
                    lock_d = 1'b1;
`ifdef SERIAL_CMP_EARLY_DONE_EN
                    state_d = ST_DONE;
`endif
                end
            end else begin
                // Later digits are more significant: any difference overrides.
                if (dig_res != CMP_EQ) begin
                    res_d = dig_res;
                end
            end
            if (last_digit) begin
                state_d = ST_DONE;
            end
        end
    end

    assign bus.L     = (res_q == CMP_LT);
    assign bus.E     = (res_q == CMP_EQ);
    assign bus.G     = (res_q == CMP_GT);
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator at WORD_W=8, DIGIT_W=2. Expected
// results come from integer comparison of operand prefixes.
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;

    localparam int WW   = 8;
    localparam int DW   = 2;
    localparam int NDIG = WW / DW;
`ifdef SERIAL_CMP_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;
    int     total = 0;
    int     bad   = 0;

    serial_magnitude_comparator_if #(.DIGIT_W(DW)) bus ();

    serial_magnitude_comparator #(
        .WORD_W  (WW),
        .DIGIT_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one clock; sampling and driving both happen 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result {L,E,G} after k accepted digits: compare the k-digit prefix that
    // has been seen, as a signed number when it contains the sign digit.
    function automatic logic [2:0] model(input logic [WW-1:0] av, input logic [WW-1:0] bv,
                                         input bit msb, input bit sgn, input int k);
        int nb;
        int pa;
        int pb;
        nb = k * DW;
        if (msb) begin
            pa = int'(av) >> (WW - nb);
            pb = int'(bv) >> (WW - nb);
        end else begin
            pa = int'(av) & ((1 << nb) - 1);
            pb = int'(bv) & ((1 << nb) - 1);
        end
        if (sgn && (msb || k == NDIG)) begin
            if (pa >= (1 << (nb - 1))) pa = pa - (1 << nb);
            if (pb >= (1 << (nb - 1))) pb = pb - (1 << nb);
        end
        if (pa < pb) return 3'b100;
        if (pa > pb) return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [2:0] leg();
        return {bus.L, bus.E, bus.G};
    endfunction

    // Issue start, then feed n_feed digits with an optional stall of gap_len
    // cycles after digit index gap_after. A full-length run also checks that
    // done and the result hold against stray valid digits.
    task automatic run_cmp(input logic [WW-1:0] av, input logic [WW-1:0] bv,
                           input bit msb, input bit sgn, input int n_feed,
                           input int gap_after, input int gap_len);
        logic [2:0] exp;
        bit         ended;
        int         d;
        bus.start      = 1'b1;
        bus.msb_first  = msb;
        bus.signed_cmp = sgn;
        bus.valid      = 1'($urandom_range(0, 1));
        bus.a          = DW'($urandom);
        bus.b          = DW'($urandom);
        cycle();
        bus.start      = 1'b0;
        bus.valid      = 1'b0;
        check("start_leg", 32'(leg()), 32'(3'b010));
        check("start_busy", 32'(bus.busy), 32'd1);
        check("start_done", 32'(bus.done), 32'd0);
        exp   = 3'b010;
        ended = 1'b0;
        for (int k = 0; k < n_feed; k++) begin
            d = msb ? (NDIG - 1 - k) : k;
            bus.valid = 1'b1;
            bus.a     = av[d*DW +: DW];
            bus.b     = bv[d*DW +: DW];
            cycle();
            bus.valid = 1'b0;
            if (!ended) begin
                exp   = model(av, bv, msb, sgn, k + 1);
                ended = (k == NDIG - 1) || (EARLY && msb && exp != 3'b010);
            end
            check("digit_leg", 32'(leg()), 32'(exp));
            check("digit_done", 32'(bus.done), 32'(ended));
            check("digit_busy", 32'(bus.busy), 32'(!ended));
            if (k == gap_after) begin
                repeat (gap_len) begin
                    cycle();
                    check("gap_leg", 32'(leg()), 32'(exp));
                    check("gap_busy", 32'(bus.busy), 32'(!ended));
                end
            end
        end
        if (n_feed == NDIG) begin
            for (int i = 0; i < 2; i++) begin
                bus.valid = 1'b1;
                bus.a     = DW'($urandom);
                bus.b     = DW'($urandom);
                cycle();
                check("hold_leg", 32'(leg()), 32'(exp));
                check("hold_done", 32'(bus.done), 32'd1);
                check("hold_state", 32'(dbg_state), 32'(ST_DONE));
            end
            bus.valid = 1'b0;
        end
    endtask

    initial begin
        logic [WW-1:0] ra;
        logic [WW-1:0] rb;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.msb_first  = 1'b0;
        bus.signed_cmp = 1'b0;
        bus.valid      = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        repeat (3) cycle();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_leg", 32'(leg()), 32'(3'b010));
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // Digits while IDLE are ignored.
        bus.valid = 1'b1;
        bus.a     = 2'd3;
        bus.b     = 2'd0;
        cycle();
        bus.valid = 1'b0;
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_leg", 32'(leg()), 32'(3'b010));

        // Directed cases.
        run_cmp(8'hA5, 8'hA5, 1'b0, 1'b0, NDIG, -1, 0);
        run_cmp(8'h80, 8'h7F, 1'b1, 1'b0, NDIG, -1, 0);
        run_cmp(8'h80, 8'h7F, 1'b1, 1'b1, NDIG, -1, 0);
        run_cmp(8'h12, 8'h21, 1'b0, 1'b0, NDIG, -1, 0);
        run_cmp(8'hFF, 8'h01, 1'b0, 1'b1, NDIG, 1, 3);
        run_cmp(8'hC0, 8'h40, 1'b1, 1'b0, NDIG, -1, 0);
        run_cmp(8'h40, 8'hC0, 1'b1, 1'b1, NDIG, -1, 0);

        // Restart from RUN after two digits, then a full equal comparison.
        run_cmp(8'h12, 8'h34, 1'b0, 1'b0, 2, -1, 0);
        run_cmp(8'h3C, 8'h3C, 1'b0, 1'b0, NDIG, -1, 0);

        // Reset in the middle of a run returns to IDLE with E set.
        run_cmp(8'h01, 8'h02, 1'b0, 1'b0, 2, -1, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_leg", 32'(leg()), 32'(3'b010));
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);

        // Randomized comparisons, some with equal operands and stalls.
        for (int n = 0; n < 40; n++) begin
            ra = WW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WW'($urandom);
            if ($urandom_range(0, 3) == 0) rb[1:0] = ~ra[1:0];
            run_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NDIG,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NDIG - 2)) : -1,
                    int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
